// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings, opcodes and the ID/EX bundle (ID_EX_ILLEGAL_FLAG_EN adds bundle.illegal)
package alu_pkg;

   localparam int ALU_XLEN   = 32;
   localparam int ALU_CTRL_W = 5;

   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_SLL  = 5'd2,
      ALU_SLT  = 5'd3,
      ALU_SLTU = 5'd4,
      ALU_XOR  = 5'd5,
      ALU_SRL  = 5'd6,
      ALU_SRA  = 5'd7,
      ALU_OR   = 5'd8,
      ALU_AND  = 5'd9,
      ALU_JALR = 5'd10,
      ALU_BEQ  = 5'd11,
      ALU_BNE  = 5'd12,
      ALU_BLT  = 5'd13,
      ALU_BGE  = 5'd14,
      ALU_BLTU = 5'd15,
      ALU_BGEU = 5'd16,
      ALU_IMM  = 5'd17
   } alu_ctrl_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [31:0] INSN_NOP = 32'h0000_0013;

   typedef struct packed {
      alu_ctrl_e             alu_ctrl;
      logic [ALU_XLEN-1:0]   op_a;
      logic [ALU_XLEN-1:0]   op_b;
      logic [ALU_XLEN-1:0]   rs2_data;
      logic [ALU_XLEN-1:0]   imm;
      logic [ALU_XLEN-1:0]   pc;
      logic [4:0]            rd;
      logic                  reg_we;
      logic                  mem_rd;
      logic                  mem_wr;
      logic [2:0]            funct3;
      logic                  is_branch;
      logic                  is_jal;
      logic                  is_jalr;
`ifdef ID_EX_ILLEGAL_FLAG_EN
      logic                  illegal;
`endif
   } ex_bundle_t;

   // alt selects SUB/SRA; only meaningful for funct3 000 and 101
   function automatic alu_ctrl_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/insn_decoder.sv
// rtl/insn_decoder.sv - combinational RV32I instruction to ex_bundle_t decode (ID_EX_ILLEGAL_FLAG_EN sets bundle.illegal)
module insn_decoder
   import alu_pkg::*;
(
   input  logic [31:0]         insn,
   input  logic [ALU_XLEN-1:0] pc,
   input  logic [ALU_XLEN-1:0] rs1_data,
   input  logic [ALU_XLEN-1:0] rs2_data,
   output ex_bundle_t          bundle
);

   logic [6:0]          opcode;
   logic [2:0]          f3;
   logic [6:0]          f7;
   logic [ALU_XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
   logic                legal;

   assign opcode = insn[6:0];
   assign f3     = insn[14:12];
   assign f7     = insn[31:25];

   assign imm_i = {{(ALU_XLEN-12){insn[31]}}, insn[31:20]};
   assign imm_s = {{(ALU_XLEN-12){insn[31]}}, insn[31:25], insn[11:7]};
   assign imm_b = {{(ALU_XLEN-13){insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_u = {{(ALU_XLEN-32){insn[31]}}, insn[31:12], 12'b0};
   assign imm_j = {{(ALU_XLEN-21){insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
   assign shamt = {{(ALU_XLEN-5){1'b0}}, insn[24:20]};

   always_comb begin
      bundle          = '0;
      legal           = 1'b0;
      bundle.alu_ctrl = ALU_ADD;
      bundle.op_a     = rs1_data;
      bundle.op_b     = rs2_data;
      bundle.rs2_data = rs2_data;
      bundle.pc       = pc;
      bundle.rd       = insn[11:7];
      bundle.funct3   = f3;

      case (opcode)
         OP_REG: begin
            legal           = (f7 == 7'b0000000) ||
                              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            bundle.alu_ctrl = alu_op_from_f3(f3, f7[5]);
            bundle.reg_we   = 1'b1;
         end
         OP_IMM: begin
            bundle.imm      = imm_i;
            bundle.op_b     = imm_i;
            bundle.reg_we   = 1'b1;
            bundle.alu_ctrl = alu_op_from_f3(f3, 1'b0);
            case (f3)
               3'b001: begin
                  legal       = (f7 == 7'b0000000);
                  bundle.op_b = shamt;
               end
               3'b101: begin
                  legal           = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                  bundle.op_b     = shamt;
                  bundle.alu_ctrl = alu_op_from_f3(f3, f7[5]);
               end
               default: legal = 1'b1;
            endcase
         end
         OP_LOAD: begin
            legal         = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            bundle.imm    = imm_i;
            bundle.op_b   = imm_i;
            bundle.mem_rd = 1'b1;
            bundle.reg_we = 1'b1;
         end
         OP_STORE: begin
            legal         = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            bundle.imm    = imm_s;
            bundle.op_b   = imm_s;
            bundle.mem_wr = 1'b1;
         end
         OP_LUI: begin
            legal           = 1'b1;
            bundle.alu_ctrl = ALU_IMM;
            bundle.imm      = imm_u;
            bundle.op_b     = imm_u;
            bundle.reg_we   = 1'b1;
         end
         OP_AUIPC: begin
            legal         = 1'b1;
            bundle.imm    = imm_u;
            bundle.op_a   = pc;
            bundle.op_b   = imm_u;
            bundle.reg_we = 1'b1;
         end
         OP_JAL: begin
            legal         = 1'b1;
            bundle.imm    = imm_j;
            bundle.op_a   = pc;
            bundle.op_b   = imm_j;
            bundle.is_jal = 1'b1;
            bundle.reg_we = 1'b1;
         end
         OP_JALR: begin
            legal           = (f3 == 3'b000);
            bundle.alu_ctrl = ALU_JALR;
            bundle.imm      = imm_i;
            bundle.op_b     = imm_i;
            bundle.is_jalr  = 1'b1;
            bundle.reg_we   = 1'b1;
         end
         OP_BRANCH: begin
            legal            = 1'b1;
            bundle.imm       = imm_b;
            bundle.is_branch = 1'b1;
            case (f3)
               3'b000:  bundle.alu_ctrl = ALU_BEQ;
               3'b001:  bundle.alu_ctrl = ALU_BNE;
               3'b100:  bundle.alu_ctrl = ALU_BLT;
               3'b101:  bundle.alu_ctrl = ALU_BGE;
               3'b110:  bundle.alu_ctrl = ALU_BLTU;
               3'b111:  bundle.alu_ctrl = ALU_BGEU;
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase

      // unlisted encodings still flow down the pipe, but as a side-effect-free ADD
      if (!legal) begin
         bundle.alu_ctrl  = ALU_ADD;
         bundle.reg_we    = 1'b0;
         bundle.mem_rd    = 1'b0;
         bundle.mem_wr    = 1'b0;
         bundle.is_branch = 1'b0;
         bundle.is_jal    = 1'b0;
         bundle.is_jalr   = 1'b0;
      end

      if (bundle.rd == 5'd0) begin
         bundle.reg_we = 1'b0;
      end

`ifdef ID_EX_ILLEGAL_FLAG_EN
      bundle.illegal = !legal && (insn != INSN_NOP);
`endif
   end

endmodule

// File: rtl/id_ex_alu_decode.sv
// rtl/id_ex_alu_decode.sv - ID decode plus ID/EX valid/ready register (ID_EX_ILLEGAL_FLAG_EN adds out_illegal)
module id_ex_alu_decode
   import alu_pkg::*;
#(
   parameter int XLEN   = ALU_XLEN,
   parameter int CTRL_W = ALU_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_insn,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_alu_ctrl,
   output logic [XLEN-1:0]   out_op_a,
   output logic [XLEN-1:0]   out_op_b,
   output logic [XLEN-1:0]   out_rs2_data,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_pc,
   output logic [4:0]        out_rd,
   output logic              out_reg_we,
   output logic              out_mem_rd,
   output logic              out_mem_wr,
   output logic [2:0]        out_funct3,
   output logic              out_is_branch,
   output logic              out_is_jal,
`ifdef ID_EX_ILLEGAL_FLAG_EN
   output logic              out_illegal,
`endif
   output logic              out_is_jalr
);

   ex_bundle_t dec;
   ex_bundle_t q;
   logic       valid_q;
   logic       capture;

   insn_decoder u_dec (
      .insn     (in_insn),
      .pc       (in_pc),
      .rs1_data (in_rs1_data),
      .rs2_data (in_rs2_data),
      .bundle   (dec)
   );

   assign in_ready = !valid_q || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   // data is only loaded on capture, so a stall or flush simply leaves it alone
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         q       <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (capture) begin
         valid_q <= 1'b1;
         q       <= dec;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid     = valid_q;
   assign out_alu_ctrl  = q.alu_ctrl;
   assign out_op_a      = q.op_a;
   assign out_op_b      = q.op_b;
   assign out_rs2_data  = q.rs2_data;
   assign out_imm       = q.imm;
   assign out_pc        = q.pc;
   assign out_rd        = q.rd;
   assign out_reg_we    = q.reg_we;
   assign out_mem_rd    = q.mem_rd;
   assign out_mem_wr    = q.mem_wr;
   assign out_funct3    = q.funct3;
   assign out_is_branch = q.is_branch;
   assign out_is_jal    = q.is_jal;
   assign out_is_jalr   = q.is_jalr;
`ifdef ID_EX_ILLEGAL_FLAG_EN
   assign out_illegal   = q.illegal;
`endif

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// tb/tb_id_ex_alu_decode.sv - directed-vector bench for id_ex_alu_decode (ID_EX_ILLEGAL_FLAG_EN enables out_illegal checks)
module tb_id_ex_alu_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_insn;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_alu_ctrl;
   logic [31:0] out_op_a;
   logic [31:0] out_op_b;
   logic [31:0] out_rs2_data;
   logic [31:0] out_imm;
   logic [31:0] out_pc;
   logic [4:0]  out_rd;
   logic        out_reg_we;
   logic        out_mem_rd;
   logic        out_mem_wr;
   logic [2:0]  out_funct3;
   logic        out_is_branch;
   logic        out_is_jal;
   logic        out_is_jalr;
`ifdef ID_EX_ILLEGAL_FLAG_EN
   logic        out_illegal;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_ex_alu_decode dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_insn       (in_insn),
      .in_pc         (in_pc),
      .in_rs1_data   (in_rs1_data),
      .in_rs2_data   (in_rs2_data),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_alu_ctrl  (out_alu_ctrl),
      .out_op_a      (out_op_a),
      .out_op_b      (out_op_b),
      .out_rs2_data  (out_rs2_data),
      .out_imm       (out_imm),
      .out_pc        (out_pc),
      .out_rd        (out_rd),
      .out_reg_we    (out_reg_we),
      .out_mem_rd    (out_mem_rd),
      .out_mem_wr    (out_mem_wr),
      .out_funct3    (out_funct3),
      .out_is_branch (out_is_branch),
      .out_is_jal    (out_is_jal),
`ifdef ID_EX_ILLEGAL_FLAG_EN
      .out_illegal   (out_illegal),
`endif
      .out_is_jalr   (out_is_jalr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [31:0] insn, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      in_valid    = 1'b1;
      in_insn     = insn;
      in_pc       = pc;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
      tick();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc = '0;
      in_rs1_data = '0; in_rs2_data = '0; flush = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_ctrl", {27'b0, out_alu_ctrl}, 32'd0);
      chk("rst_op_a", out_op_a, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // sub x3,x1,x2
      apply(32'h402081B3, 32'h0, 32'd10, 32'd3);
      chk("sub_valid", {31'b0, out_valid}, 32'd1);
      chk("sub_ctrl", {27'b0, out_alu_ctrl}, 32'd1);
      chk("sub_op_a", out_op_a, 32'd10);
      chk("sub_op_b", out_op_b, 32'd3);
      chk("sub_rd", {27'b0, out_rd}, 32'd3);
      chk("sub_we", {31'b0, out_reg_we}, 32'd1);

      // blt x1,x2,-8
      apply(32'hFE20CCE3, 32'h40, 32'd1, 32'd7);
      chk("blt_ctrl", {27'b0, out_alu_ctrl}, 32'd13);
      chk("blt_br", {31'b0, out_is_branch}, 32'd1);
      chk("blt_imm", out_imm, 32'hFFFFFFF8);
      chk("blt_we", {31'b0, out_reg_we}, 32'd0);
      chk("blt_op_b", out_op_b, 32'd7);

      // lui x5,0x12345 then auipc x6,1 at 0x100, back to back
      apply(32'h123452B7, 32'hFC, 32'd0, 32'd0);
      chk("lui_ctrl", {27'b0, out_alu_ctrl}, 32'd17);
      chk("lui_op_b", out_op_b, 32'h12345000);
      chk("lui_we", {31'b0, out_reg_we}, 32'd1);
      apply(32'h00001317, 32'h100, 32'd0, 32'd0);
      chk("auipc_valid", {31'b0, out_valid}, 32'd1);
      chk("auipc_ctrl", {27'b0, out_alu_ctrl}, 32'd0);
      chk("auipc_op_a", out_op_a, 32'h100);
      chk("auipc_op_b", out_op_b, 32'h1000);

      // back-pressure with addi x7,x0,5 waiting
      out_ready = 1'b0;
      in_valid = 1'b1; in_insn = 32'h00500393; in_pc = 32'h104; in_rs1_data = 32'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         tick();
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_rd", {27'b0, out_rd}, 32'd6);
         chk("stall_op_b", out_op_b, 32'h1000);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("addi_rd", {27'b0, out_rd}, 32'd7);
      chk("addi_op_b", out_op_b, 32'd5);
      chk("addi_pc", out_pc, 32'h104);
      tick();
      chk("drain_valid", {31'b0, out_valid}, 32'd0);

      // srai x1,x2,3 ; lw x4,8(x1) ; sw x2,4(x1) ; add x0,x1,x2 ; xor with funct7=0x20 ; jal x1,+16
      apply(32'h40315093, 32'h0, 32'hF0, 32'd0);
      chk("srai_ctrl", {27'b0, out_alu_ctrl}, 32'd7);
      chk("srai_op_b", out_op_b, 32'd3);
      apply(32'h0080A203, 32'h0, 32'h1000, 32'd0);
      chk("lw_rd", {31'b0, out_mem_rd}, 32'd1);
      chk("lw_op_b", out_op_b, 32'd8);
      chk("lw_f3", {29'b0, out_funct3}, 32'd2);
      apply(32'h0020A223, 32'h0, 32'h1000, 32'hAB);
      chk("sw_wr", {31'b0, out_mem_wr}, 32'd1);
      chk("sw_imm", out_imm, 32'd4);
      chk("sw_data", out_rs2_data, 32'hAB);
      chk("sw_we", {31'b0, out_reg_we}, 32'd0);
      apply(32'h00208033, 32'h0, 32'd1, 32'd2);
      chk("x0_we", {31'b0, out_reg_we}, 32'd0);
      apply(32'h4020C1B3, 32'h0, 32'd1, 32'd2);
      chk("badxor_valid", {31'b0, out_valid}, 32'd1);
      chk("badxor_ctrl", {27'b0, out_alu_ctrl}, 32'd0);
      chk("badxor_we", {31'b0, out_reg_we}, 32'd0);
      apply(32'h010000EF, 32'h200, 32'd0, 32'd0);
      chk("jal_flag", {31'b0, out_is_jal}, 32'd1);
      chk("jal_op_b", out_op_b, 32'd16);
      chk("jal_op_a", out_op_a, 32'h200);

      // flush with a registered entry and a new capture pending
      out_ready = 1'b0;
      flush = 1'b1;
      apply(32'h123452B7, 32'h0, 32'd0, 32'd0);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      tick();
      chk("flush_discard", {31'b0, out_valid}, 32'd0);

      // reset during a stall
      apply(32'h402081B3, 32'h0, 32'd10, 32'd3);
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      chk("prerst_valid", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midstall_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("midstall_rst_ctrl", {27'b0, out_alu_ctrl}, 32'd0);
      out_ready = 1'b1;

`ifdef ID_EX_ILLEGAL_FLAG_EN
      apply(32'h00000000, 32'h0, 32'd0, 32'd0);
      chk("ill_zero", {31'b0, out_illegal}, 32'd1);
      chk("ill_zero_we", {31'b0, out_reg_we}, 32'd0);
      apply(32'h00000013, 32'h0, 32'd0, 32'd0);
      chk("ill_nop", {31'b0, out_illegal}, 32'd0);
      apply(32'h4020C1B3, 32'h0, 32'd0, 32'd0);
      chk("ill_badxor", {31'b0, out_illegal}, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
